// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared LIF state encoding and default neuron constants
package lif_pkg;

   localparam int DEF_DATA_W     = 8;
   localparam int DEF_THRESHOLD  = 128;
   localparam int DEF_LEAK_SHIFT = 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      UPDATE = 3'd2,
      EMIT   = 3'd3,
      DONE   = 3'd4
   } lif_state_e;

endpackage

// File: rtl/lif_layer_scheduler_if.sv
// rtl/lif_layer_scheduler_if.sv - step, current and spike handshakes of the layer scheduler
interface lif_layer_scheduler_if
   import lif_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int IDX_W  = 4
) ();

   logic              step_valid;
   logic              step_ready;
   logic              clear;
   logic              cur_valid;
   logic              cur_ready;
   logic [DATA_W-1:0] cur_data;
   logic              spike_valid;
   logic              spike_ready;
   logic [IDX_W-1:0]  spike_idx;
   logic              spike_fired;
   logic              step_done;

   modport master (
      output step_valid, clear, cur_valid, cur_data, spike_ready,
      input  step_ready, cur_ready, spike_valid, spike_idx, spike_fired, step_done
   );

   modport slave (
      input  step_valid, clear, cur_valid, cur_data, spike_ready,
      output step_ready, cur_ready, spike_valid, spike_idx, spike_fired, step_done
   );

endinterface

// File: rtl/lif_update_unit.sv
// rtl/lif_update_unit.sv - combinational LIF update: threshold, leak and saturating integrate
module lif_update_unit
   import lif_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int THRESHOLD  = DEF_THRESHOLD,
   parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
   input  logic [DATA_W-1:0] v_i,
   input  logic [DATA_W-1:0] cur_i,
   output logic [DATA_W-1:0] next_v_o,
   output logic              fired_o
);

   localparam logic [DATA_W:0] TH_EXT = (DATA_W+1)'(THRESHOLD);

   logic [DATA_W:0] sum;

   always_comb begin
      sum     = {1'b0, v_i >> LEAK_SHIFT} + {1'b0, cur_i};
      fired_o = ({1'b0, v_i} >= TH_EXT);
      // A firing neuron discards this step's current and restarts from zero.
      if (fired_o) begin
         next_v_o = '0;
      end else if (sum[DATA_W]) begin
         next_v_o = '1;
      end else begin
         next_v_o = sum[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/lif_layer_scheduler.sv
// rtl/lif_layer_scheduler.sv - walks one LIF update datapath across all neurons of a layer per timestep
module lif_layer_scheduler
   import lif_pkg::*;
#(
   parameter int N_NEURONS  = 16,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int THRESHOLD  = DEF_THRESHOLD,
   parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
   input  logic                 clk,
   input  logic                 reset,
   lif_layer_scheduler_if.slave bus
);

   localparam int IDX_W = $clog2(N_NEURONS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

   localparam logic [2:0] ST_IDLE   = IDLE;
   localparam logic [2:0] ST_LOAD   = LOAD;
   localparam logic [2:0] ST_UPDATE = UPDATE;
   localparam logic [2:0] ST_EMIT   = EMIT;
   localparam logic [2:0] ST_DONE   = DONE;

   logic [2:0]        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] cur_q;
   logic [DATA_W-1:0] pot_q [N_NEURONS];
   logic              spike_fired_q;
   logic [IDX_W-1:0]  spike_idx_q;

   logic [DATA_W-1:0] upd_next_v;
   logic              upd_fired;
   logic              clear_en;

   lif_update_unit #(
      .DATA_W     (DATA_W),
      .THRESHOLD  (THRESHOLD),
      .LEAK_SHIFT (LEAK_SHIFT)
   ) u_update (
      .v_i      (pot_q[idx_q]),
      .cur_i    (cur_q),
      .next_v_o (upd_next_v),
      .fired_o  (upd_fired)
   );

   // A simultaneous step request takes priority over clear.
   assign clear_en = (state_q == ST_IDLE) && bus.clear && !bus.step_valid;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE:   if (bus.step_valid) state_d = ST_LOAD;
         ST_LOAD:   if (bus.cur_valid) state_d = ST_UPDATE;
         ST_UPDATE: state_d = ST_EMIT;
         ST_EMIT: begin
            if (bus.spike_ready) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_LOAD;
               end
            end
         end
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         cur_q         <= '0;
         spike_fired_q <= 1'b0;
         spike_idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (state_q == ST_LOAD && bus.cur_valid) begin
            cur_q <= bus.cur_data;
         end
         if (state_q == ST_UPDATE) begin
            spike_fired_q <= upd_fired;
            spike_idx_q   <= idx_q;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_NEURONS; i++) pot_q[i] <= '0;
      end else if (clear_en) begin
         for (int i = 0; i < N_NEURONS; i++) pot_q[i] <= '0;
      end else if (state_q == ST_UPDATE) begin
         pot_q[idx_q] <= upd_next_v;
      end
   end

   assign bus.step_ready  = (state_q == ST_IDLE);
   assign bus.cur_ready   = (state_q == ST_LOAD);
   assign bus.spike_valid = (state_q == ST_EMIT);
   assign bus.spike_idx   = spike_idx_q;
   assign bus.spike_fired = spike_fired_q;
   assign bus.step_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// tb/tb_lif_layer_scheduler.sv - scoreboard bench for the LIF layer scheduler
module tb_lif_layer_scheduler;
   import lif_pkg::*;

   localparam int N  = 16;
   localparam int DW = 8;
   localparam int IW = 4;
   localparam int TH = 128;

   typedef struct {
      int   idx;
      logic fired;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   lif_layer_scheduler_if #(.DATA_W(DW), .IDX_W(IW)) bus ();
   lif_layer_scheduler_if #(.DATA_W(DW), .IDX_W(1))  bus_b ();

   lif_layer_scheduler #(.N_NEURONS(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   lif_layer_scheduler #(.N_NEURONS(2), .THRESHOLD(255)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  model_pot [N];
   logic [7:0]  model_pot_b [2];
   logic [7:0]  cur_tab [N];
   exp_t        exp_q [$];
   exp_t        exp_b_q [$];

   function automatic void model_update(input logic [7:0] v, input logic [7:0] cur, input int th,
                                        output logic [7:0] nv, output logic f);
      logic [8:0] s;
      if (int'(v) >= th) begin
         f  = 1'b1;
         nv = 8'd0;
      end else begin
         f  = 1'b0;
         s  = {1'b0, v >> 1} + {1'b0, cur};
         nv = s[8] ? 8'hFF : s[7:0];
      end
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < N; i++) model_pot[i] = 8'd0;
      model_pot_b[0] = 8'd0;
      model_pot_b[1] = 8'd0;
      exp_q.delete();
      exp_b_q.delete();
   endtask

   task automatic check_pots(input string tag);
      for (int i = 0; i < N; i++) begin
         n_checks++;
         if (dut.pot_q[i] !== model_pot[i]) begin
            n_fail++;
            $display("FAIL %s pot[%0d]: got %0d expected %0d", tag, i, dut.pot_q[i], model_pot[i]);
         end
      end
   endtask

   task automatic run_step(input bit gaps, input bit with_clear, input int bp_idx);
      int         nidx = 0;
      int         n_res = 0;
      bit         done = 1'b0;
      bit         bp_done = 1'b0;
      exp_t       e;
      logic [7:0] nv;
      logic       f;
      logic [3:0] snap_idx;
      logic       snap_fired;
      @(negedge clk);
      n_checks++;
      if (bus.step_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL step_ready_idle: got %b expected 1", bus.step_ready);
      end
      bus.step_valid = 1'b1;
      bus.clear      = with_clear;
      @(negedge clk);
      bus.step_valid = 1'b0;
      bus.clear      = 1'b0;
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         if (bus.step_done) begin
            done = 1'b1;
         end else begin
            bus.cur_valid   = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.spike_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (bp_idx >= 0 && !bp_done && bus.spike_valid && int'(bus.spike_idx) == bp_idx) begin
               bus.spike_ready = 1'b0;
               snap_idx   = bus.spike_idx;
               snap_fired = bus.spike_fired;
               repeat (5) begin
                  @(negedge clk);
                  n_checks++;
                  if (bus.spike_valid !== 1'b1 || bus.spike_idx !== snap_idx || bus.spike_fired !== snap_fired) begin
                     n_fail++;
                     $display("FAIL backpressure_hold: got v=%b idx=%0d f=%b expected v=1 idx=%0d f=%b",
                              bus.spike_valid, bus.spike_idx, bus.spike_fired, snap_idx, snap_fired);
                  end
               end
               bp_done = 1'b1;
               bus.spike_ready = 1'b1;
            end
            if (nidx < N) bus.cur_data = cur_tab[nidx];
            if (bus.cur_ready && bus.cur_valid && nidx < N) begin
               model_update(model_pot[nidx], cur_tab[nidx], TH, nv, f);
               model_pot[nidx] = nv;
               exp_q.push_back('{idx: nidx, fired: f});
               nidx++;
            end
            if (bus.spike_valid && bus.spike_ready) begin
               n_checks++;
               n_res++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL spike_unexpected: got idx=%0d expected none", bus.spike_idx);
               end else begin
                  e = exp_q.pop_front();
                  if (int'(bus.spike_idx) !== e.idx || bus.spike_fired !== e.fired) begin
                     n_fail++;
                     $display("FAIL spike_result: got idx=%0d fired=%b expected idx=%0d fired=%b",
                              bus.spike_idx, bus.spike_fired, e.idx, e.fired);
                  end
               end
            end
            @(negedge clk);
         end
      end
      bus.cur_valid   = 1'b0;
      bus.spike_ready = 1'b0;
      n_checks++;
      if (!done || n_res != N || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL step_complete: got done=%b results=%0d pending=%0d expected done=1 results=%0d pending=0",
                  done, n_res, exp_q.size(), N);
      end
      @(negedge clk);
      n_checks++;
      if (bus.step_done !== 1'b0 || bus.step_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL done_pulse_width: got done=%b ready=%b expected done=0 ready=1", bus.step_done, bus.step_ready);
      end
   endtask

   task automatic run_step_b(input logic [7:0] c0);
      int         nidx = 0;
      bit         done = 1'b0;
      exp_t       e;
      logic [7:0] nv;
      logic       f;
      @(negedge clk);
      bus_b.step_valid = 1'b1;
      @(negedge clk);
      bus_b.step_valid  = 1'b0;
      bus_b.cur_valid   = 1'b1;
      bus_b.spike_ready = 1'b1;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         if (bus_b.step_done) begin
            done = 1'b1;
         end else begin
            bus_b.cur_data = (nidx == 0) ? c0 : 8'd0;
            if (bus_b.cur_ready && nidx < 2) begin
               model_update(model_pot_b[nidx], bus_b.cur_data, 255, nv, f);
               model_pot_b[nidx] = nv;
               exp_b_q.push_back('{idx: nidx, fired: f});
               nidx++;
            end
            if (bus_b.spike_valid) begin
               n_checks++;
               if (exp_b_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL sat_spike_unexpected: got idx=%0d expected none", bus_b.spike_idx);
               end else begin
                  e = exp_b_q.pop_front();
                  if (int'(bus_b.spike_idx) !== e.idx || bus_b.spike_fired !== e.fired) begin
                     n_fail++;
                     $display("FAIL sat_spike_result: got idx=%0d fired=%b expected idx=%0d fired=%b",
                              bus_b.spike_idx, bus_b.spike_fired, e.idx, e.fired);
                  end
               end
            end
            @(negedge clk);
         end
      end
      bus_b.cur_valid   = 1'b0;
      bus_b.spike_ready = 1'b0;
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL sat_step_timeout: got no step_done expected step_done");
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (bus.step_ready !== 1'b1 || bus.cur_ready !== 1'b0 || bus.spike_valid !== 1'b0 ||
          bus.spike_idx !== 4'd0 || bus.spike_fired !== 1'b0 || bus.step_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got sr=%b cr=%b sv=%b si=%0d sf=%b sd=%b expected 1 0 0 0 0 0",
                  bus.step_ready, bus.cur_ready, bus.spike_valid, bus.spike_idx, bus.spike_fired, bus.step_done);
      end
      check_pots("reset");
   endtask

   task automatic test_leak_integrate();
      logic [7:0] exp_v [3];
      exp_v = '{8'd60, 8'd90, 8'd105};
      do_reset();
      for (int i = 0; i < N; i++) cur_tab[i] = 8'd0;
      cur_tab[0] = 8'd60;
      for (int s = 0; s < 3; s++) begin
         run_step(1'b0, 1'b0, -1);
         n_checks++;
         if (dut.pot_q[0] !== exp_v[s]) begin
            n_fail++;
            $display("FAIL leak_integrate step%0d: got %0d expected %0d", s, dut.pot_q[0], exp_v[s]);
         end
      end
   endtask

   task automatic test_fire_reset();
      logic [7:0] exp_v [4];
      exp_v = '{8'd100, 8'd150, 8'd0, 8'd100};
      do_reset();
      for (int i = 0; i < N; i++) cur_tab[i] = 8'd0;
      cur_tab[0] = 8'd100;
      for (int s = 0; s < 4; s++) begin
         run_step(1'b0, 1'b0, -1);
         n_checks++;
         if (dut.pot_q[0] !== exp_v[s]) begin
            n_fail++;
            $display("FAIL fire_reset step%0d: got %0d expected %0d", s, dut.pot_q[0], exp_v[s]);
         end
      end
   endtask

   task automatic test_saturation();
      logic [7:0] exp_v [3];
      logic [7:0] cur_v [3];
      exp_v = '{8'd200, 8'd255, 8'd0};
      cur_v = '{8'd200, 8'd250, 8'd250};
      do_reset();
      for (int s = 0; s < 3; s++) begin
         run_step_b(cur_v[s]);
         n_checks++;
         if (dut_b.pot_q[0] !== exp_v[s]) begin
            n_fail++;
            $display("FAIL saturation step%0d: got %0d expected %0d", s, dut_b.pot_q[0], exp_v[s]);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < N; i++) cur_tab[i] = 8'($urandom_range(0, 255));
      run_step(1'b0, 1'b0, 3);
      run_step(1'b0, 1'b0, 7);
      check_pots("backpressure");
   endtask

   task automatic test_random_full();
      do_reset();
      for (int s = 0; s < 4; s++) begin
         for (int i = 0; i < N; i++) cur_tab[i] = 8'($urandom_range(0, 255));
         run_step(1'b1, 1'b0, -1);
      end
      check_pots("random_full");
   endtask

   task automatic test_reset_mid_step();
      bit hit = 1'b0;
      do_reset();
      for (int i = 0; i < N; i++) cur_tab[i] = 8'($urandom_range(1, 120));
      @(negedge clk);
      bus.step_valid = 1'b1;
      @(negedge clk);
      bus.step_valid = 1'b0;
      for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
         if (bus.spike_valid && bus.spike_idx == 4'd7) begin
            hit = 1'b1;
         end else begin
            bus.cur_valid   = 1'b1;
            bus.spike_ready = 1'b1;
            bus.cur_data    = 8'($urandom_range(1, 120));
            @(negedge clk);
         end
      end
      n_checks++;
      if (!hit) begin
         n_fail++;
         $display("FAIL reach_idx7: got no EMIT of idx 7 expected EMIT of idx 7");
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (bus.step_ready !== 1'b1 || bus.cur_ready !== 1'b0 || bus.spike_valid !== 1'b0 ||
          bus.spike_idx !== 4'd0 || bus.spike_fired !== 1'b0 || bus.step_done !== 1'b0) begin
         n_fail++;
         $display("FAIL midstep_reset_outputs: got sr=%b cr=%b sv=%b si=%0d sf=%b sd=%b expected 1 0 0 0 0 0",
                  bus.step_ready, bus.cur_ready, bus.spike_valid, bus.spike_idx, bus.spike_fired, bus.step_done);
      end
      bus.cur_valid   = 1'b0;
      bus.spike_ready = 1'b0;
      do_reset();
      check_pots("midstep_reset");
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         n_checks++;
         if (bus.step_done !== 1'b0 || bus.step_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL no_done_after_abort: got done=%b ready=%b expected done=0 ready=1",
                     bus.step_done, bus.step_ready);
         end
      end
   endtask

   task automatic test_clear();
      do_reset();
      for (int i = 0; i < N; i++) cur_tab[i] = 8'($urandom_range(10, 100));
      run_step(1'b0, 1'b0, -1);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      for (int i = 0; i < N; i++) model_pot[i] = 8'd0;
      n_checks++;
      if (bus.step_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_stays_idle: got step_ready=%b expected 1", bus.step_ready);
      end
      check_pots("clear");
      for (int i = 0; i < N; i++) cur_tab[i] = 8'($urandom_range(10, 100));
      run_step(1'b0, 1'b0, -1);
      for (int i = 0; i < N; i++) cur_tab[i] = 8'($urandom_range(0, 60));
      run_step(1'b0, 1'b1, -1);
      check_pots("step_with_clear");
   endtask

   initial begin
      bus.step_valid   = 1'b0;
      bus.clear        = 1'b0;
      bus.cur_valid    = 1'b0;
      bus.cur_data     = 8'd0;
      bus.spike_ready  = 1'b0;
      bus_b.step_valid = 1'b0;
      bus_b.clear      = 1'b0;
      bus_b.cur_valid  = 1'b0;
      bus_b.cur_data   = 8'd0;
      bus_b.spike_ready = 1'b0;
      test_reset();
      test_leak_integrate();
      test_fire_reset();
      test_saturation();
      test_backpressure();
      test_random_full();
      test_reset_mid_step();
      test_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
